// File: rtl/fft32_input_loader.sv
// Ping-pong frame loader feeding the FFT32 control unit.
// Writes 32-sample frames into alternating RAM banks at bit-reversed addresses.
module fft32_input_loader #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_re,
  input  logic [DATA_W-1:0] i_im,
  output logic              o_wr_en,
  output logic              o_wr_bank,
  output logic [4:0]        o_wr_addr,
  output logic [DATA_W-1:0] o_wr_re,
  output logic [DATA_W-1:0] o_wr_im,
  output logic              o_start,
  output logic              o_rd_bank,
  output logic              o_busy,
  input  logic              i_fft_done
);

  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(31);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_d;
  logic             done_q;
  logic             accept, done_rise;
  logic             start_d, ready_d, busy_d;

  function automatic logic [CNT_W-1:0] bitrev(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    for (int i = 0; i < int'(CNT_W); i++) r[i] = v[CNT_W-1-i];
    return r;
  endfunction

  // Frame fill, bank ownership and start/release sequencing
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = o_rd_bank;
    start_d   = 1'b0;
    accept    = i_valid & o_ready;
    done_rise = i_fft_done & ~done_q;

    if (accept) begin
      if (cnt_q == CNT_LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        cnt_d             = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (full_q[o_rd_bank]) begin
          start_d = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (done_rise) begin
          full_d[o_rd_bank] = 1'b0;
          rd_bank_d         = ~o_rd_bank;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A bank that is full on the next cycle must not be offered to the source
    ready_d = ~full_d[wr_bank_d];
    busy_d  = (state_d == RUN);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      done_q    <= 1'b0;
      o_rd_bank <= 1'b0;
      o_ready   <= 1'b0;
      o_start   <= 1'b0;
      o_busy    <= 1'b0;
      o_wr_en   <= 1'b0;
      o_wr_bank <= 1'b0;
      o_wr_addr <= '0;
      o_wr_re   <= '0;
      o_wr_im   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      done_q    <= i_fft_done;
      o_rd_bank <= rd_bank_d;
      o_ready   <= ready_d;
      o_start   <= start_d;
      o_busy    <= busy_d;
      o_wr_en   <= accept;
      if (accept) begin
        o_wr_bank <= wr_bank_q;
        o_wr_addr <= bitrev(cnt_q);
        o_wr_re   <= i_re;
        o_wr_im   <= i_im;
      end
    end
  end

endmodule
